// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, control-word fields and opcodes for the register/ALU stage
package alu_pkg;

  localparam int DW   = 4;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);
  localparam int OPW  = 5;

  localparam int SRCA_MSB = 13;
  localparam int SRCB_MSB = 10;
  localparam int DEST_MSB = 7;
  localparam int OP_MSB   = 4;

  localparam logic [OPW-1:0] OP_LOADIN = 5'b00000;
  localparam logic [OPW-1:0] OP_ADD    = 5'b00001;
  localparam logic [OPW-1:0] OP_SUB    = 5'b00010;
  localparam logic [OPW-1:0] OP_AND    = 5'b00011;
  localparam logic [OPW-1:0] OP_OR     = 5'b00100;
  localparam logic [OPW-1:0] OP_XOR    = 5'b00101;
  localparam logic [OPW-1:0] OP_NOT    = 5'b00110;
  localparam logic [OPW-1:0] OP_PASS   = 5'b00111;
  localparam logic [OPW-1:0] OP_INC    = 5'b01000;
  localparam logic [OPW-1:0] OP_DEC    = 5'b01001;
  localparam logic [OPW-1:0] OP_SHL    = 5'b01010;
  localparam logic [OPW-1:0] OP_SHR    = 5'b01011;

endpackage

// File: rtl/register_and_alu_unit_if.sv
// rtl/register_and_alu_unit_if.sv - control/data bus between the CPU sequencer and the execute stage
interface register_and_alu_unit_if;
  import alu_pkg::*;

  logic [DW-1:0] in;
  logic [13:0]   control;
  logic [DW-1:0] out;

  modport master (output in, output control, input out);
  modport slave  (input in, input control, output out);

endinterface

// File: rtl/register_and_alu_unit_alu4.sv
// rtl/register_and_alu_unit_alu4.sv - combinational 4-bit ALU, reserved opcodes yield zero
module alu4
  import alu_pkg::*;
(
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [DW-1:0]  din,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  result
);

  always_comb begin
    result = '0;
    case (op)
      OP_LOADIN: result = din;
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NOT:    result = ~a;
      OP_PASS:   result = a;
      OP_INC:    result = a + DW'(1);
      OP_DEC:    result = a - DW'(1);
      OP_SHL:    result = {a[DW-2:0], 1'b0};
      OP_SHR:    result = {1'b0, a[DW-1:1]};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/register_and_alu_unit.sv
// rtl/register_and_alu_unit.sv - 8x4 register file feeding alu4, result written back each clock
module register_and_alu_unit
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  register_and_alu_unit_if.slave bus
);

  logic [DW-1:0]  regs [NREG];
  logic [AW-1:0]  srca;
  logic [AW-1:0]  srcb;
  logic [AW-1:0]  dest;
  logic [OPW-1:0] op;
  logic [DW-1:0]  opa;
  logic [DW-1:0]  opb;
  logic [DW-1:0]  result;

  assign srca = bus.control[SRCA_MSB -: AW];
  assign srcb = bus.control[SRCB_MSB -: AW];
  assign dest = bus.control[DEST_MSB -: AW];
  assign op   = bus.control[OP_MSB -: OPW];

  // R0 is never written after reset, so a plain read returns the constant zero.
  assign opa = regs[srca];
  assign opb = regs[srcb];

  alu4 u_alu (
    .a      (opa),
    .b      (opb),
    .din    (bus.in),
    .op     (op),
    .result (result)
  );

  assign bus.out = result;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (dest != '0) begin
      regs[dest] <= result;
    end
  end

endmodule

// File: tb/tb_register_and_alu_unit.sv
// tb/tb_register_and_alu_unit.sv - directed vectors plus randomized instructions against a register model
module tb_register_and_alu_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mreg [8];

  register_and_alu_unit_if bus ();

  register_and_alu_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] c;
    logic [3:0]  d;
    logic        r;
    logic [3:0]  e;
  } vec_t;

  vec_t vecs [14];

  function automatic int model_alu(input int a, input int b, input int d, input int op);
    case (op)
      0:       return d;
      1:       return (a + b) % 16;
      2:       return (a - b + 16) % 16;
      3:       return a & b;
      4:       return a | b;
      5:       return a ^ b;
      6:       return 15 - a;
      7:       return a;
      8:       return (a + 1) % 16;
      9:       return (a + 15) % 16;
      10:      return (a * 2) % 16;
      11:      return a / 2;
      default: return 0;
    endcase
  endfunction

  task automatic step(input logic [13:0] c, input logic [3:0] d, input logic r,
                      input logic [3:0] e, input bit use_model, input string name);
    int a, b, dst, res;
    logic [3:0] req;
    @(negedge clk);
    bus.control = c;
    bus.in      = d;
    rst         = r;
    #1;
    a   = mreg[c[13:11]];
    b   = mreg[c[10:8]];
    dst = int'(c[7:5]);
    res = model_alu(a, b, int'(d), int'(c[4:0]));
    req = use_model ? 4'(res) : e;
    checks++;
    if (bus.out !== req) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b (control=%b in=%b)", name, bus.out, req, c, d);
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 8; i++) mreg[i] = 0;
    end else if (dst != 0) begin
      mreg[dst] = res;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    bus.control = '0;
    bus.in      = '0;

    vecs[0]  = '{14'b001_010_000_00001, 4'b0000, 1'b0, 4'b0000};
    vecs[1]  = '{14'b000_000_001_00000, 4'b1000, 1'b0, 4'b1000};
    vecs[2]  = '{14'b000_000_010_00000, 4'b1010, 1'b0, 4'b1010};
    vecs[3]  = '{14'b010_001_011_00010, 4'b0000, 1'b0, 4'b0010};
    vecs[4]  = '{14'b011_000_000_00111, 4'b0000, 1'b0, 4'b0010};
    vecs[5]  = '{14'b010_001_100_00001, 4'b0000, 1'b0, 4'b0010};
    vecs[6]  = '{14'b001_010_000_00010, 4'b0000, 1'b0, 4'b1110};
    vecs[7]  = '{14'b000_000_000_00000, 4'b1111, 1'b0, 4'b1111};
    vecs[8]  = '{14'b000_000_000_00111, 4'b0000, 1'b0, 4'b0000};
    vecs[9]  = '{14'b001_000_001_01000, 4'b0000, 1'b0, 4'b1001};
    vecs[10] = '{14'b001_000_000_00111, 4'b0000, 1'b0, 4'b1001};
    vecs[11] = '{14'b000_000_001_00000, 4'b0101, 1'b1, 4'b0101};
    vecs[12] = '{14'b001_000_000_00111, 4'b0000, 1'b0, 4'b0000};
    vecs[13] = '{14'b100_000_000_00111, 4'b0000, 1'b0, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].c, vecs[i].d, vecs[i].r, vecs[i].e, 1'b0, $sformatf("vec%0d", i));
    end

    // Load non-zero registers so reserved opcodes are tested against live operands.
    for (int i = 1; i < 8; i++) begin
      step({3'b000, 3'b000, 3'(i), 5'b00000}, 4'(i + 8), 1'b0, 4'(i + 8), 1'b0, "load");
    end
    for (int op = 12; op < 32; op++) begin
      step({3'b011, 3'b101, 3'b000, 5'(op)}, 4'b1111, 1'b0, 4'b0000, 1'b0,
           $sformatf("reserved_op%0d", op));
    end

    for (int n = 0; n < 300; n++) begin
      logic [13:0] c;
      logic [3:0]  d;
      logic        r;
      c = 14'($urandom);
      c[4:0] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(12, 31)) : 5'($urandom_range(0, 11));
      d = 4'($urandom);
      r = ($urandom_range(0, 31) == 0);
      step(c, d, r, 4'b0000, 1'b1, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
